// File: rtl/apb_mem.sv
// APB3 slave word memory with a fixed number of access-phase wait states.
// Out-of-range transfers complete with PSlvErr and never touch the array.
module apb_mem #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] PAddr,
  input  logic              PWrite,
  input  logic              PSel,
  input  logic              PEnable,
  input  logic [DATA_W-1:0] PWData,
  output logic [DATA_W-1:0] PRData,
  output logic              PReady,
  output logic              PSlvErr
);

  localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [IDX_W-1:0]  r_addr;
  logic              r_write;
  logic              r_err;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [DATA_W-1:0] memory [0:DEPTH-1];

  logic              w_err_in;
  logic              w_ready;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_idx;

  assign w_idx    = PAddr[IDX_W-1:0];
  assign w_err_in = ({1'b0, PAddr} >= LIMIT);
  // Handshake outputs come only from registered state, never from the bus inputs.
  assign w_ready  = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign w_wr_en  = w_ready && PSel && PEnable && r_write && !r_err;

  assign PReady  = w_ready;
  assign PSlvErr = w_ready & r_err;
  assign PRData  = r_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // PSel with PEnable already high has no setup phase and is ignored.
          if (PSel && !PEnable) begin
            r_state <= ACCESS;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_addr  <= w_idx;
            r_write <= PWrite;
            r_wdata <= PWData;
            r_err   <= w_err_in;
            if (!PWrite) r_rdata <= w_err_in ? '0 : memory[w_idx];
          end
        end
        ACCESS: begin
          if (!PSel)                 r_state <= IDLE;
          else if (r_cnt != 4'd0)    r_cnt   <= r_cnt - 4'd1;
          else if (PEnable)          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive Rst, and a reset-free
  // block lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) memory[r_addr] <= r_wdata;
  end

endmodule

// File: tb/tb_apb_mem.sv
// Directed bench for apb_mem: three instances (0, 2 and 3 wait states) share
// one bus; a model memory and a scoreboard queue supply every expected value.
module tb_apb_mem;

  localparam int WAITS [3] = '{0, 2, 3};

  typedef struct {
    logic        err;
    logic        is_rd;
    logic [31:0] rd;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        Rst;
  logic [15:0] PAddr;
  logic        PWrite;
  logic [2:0]  psel;
  logic        PEnable;
  logic [31:0] PWData;
  logic [31:0] prdata [3];
  logic [2:0]  rdy;
  logic [2:0]  slverr;

  logic [31:0] mdl [3][256];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  apb_mem #(.WAIT_CYCLES(0)) mem (
    .clk(clk), .Rst(Rst), .PAddr(PAddr), .PWrite(PWrite), .PSel(psel[0]),
    .PEnable(PEnable), .PWData(PWData), .PRData(prdata[0]),
    .PReady(rdy[0]), .PSlvErr(slverr[0])
  );

  apb_mem #(.WAIT_CYCLES(2)) mem_w2 (
    .clk(clk), .Rst(Rst), .PAddr(PAddr), .PWrite(PWrite), .PSel(psel[1]),
    .PEnable(PEnable), .PWData(PWData), .PRData(prdata[1]),
    .PReady(rdy[1]), .PSlvErr(slverr[1])
  );

  apb_mem #(.WAIT_CYCLES(3)) mem_w3 (
    .clk(clk), .Rst(Rst), .PAddr(PAddr), .PWrite(PWrite), .PSel(psel[2]),
    .PEnable(PEnable), .PWData(PWData), .PRData(prdata[2]),
    .PReady(rdy[2]), .PSlvErr(slverr[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input int k, input logic [7:0] a);
    case (k)
      0:       return mem.memory[a];
      1:       return mem_w2.memory[a];
      default: return mem_w3.memory[a];
    endcase
  endfunction

  // One complete transfer on instance k; address/data are scrambled during waits.
  task automatic xfer(input int k, input logic [15:0] a, input logic [31:0] d, input logic w);
    exp_t       e;
    int         n;
    logic [7:0] ix;
    ix      = a[7:0];
    e.err   = (a >= 16'd256);
    e.is_rd = !w;
    e.rd    = e.err ? 32'h0 : mdl[k][ix];
    e.waits = WAITS[k];
    sb.push_back(e);
    @(negedge clk);
    psel[k] = 1'b1; PEnable = 1'b0; PAddr = a; PWData = d; PWrite = w;
    @(negedge clk);
    PEnable = 1'b1;
    n = 0;
    while (rdy[k] !== 1'b1 && n <= 20) begin
      if (w) check("mem_during_wait", mem_word(k, ix), mdl[k][ix]);
      PAddr  = ~a;
      PWData = ~d;
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check("wait_cycles", n, e.waits);
    check("slverr", {31'b0, slverr[k]}, {31'b0, e.err});
    if (e.is_rd) check("prdata", prdata[k], e.rd);
    @(negedge clk);
    psel[k] = 1'b0; PEnable = 1'b0;
    check("ready_drop", {31'b0, rdy[k]}, 32'h0);
    check("slverr_drop", {31'b0, slverr[k]}, 32'h0);
    if (w && !e.err) mdl[k][ix] = d;
    check("mem_after", mem_word(k, ix), mdl[k][ix]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    Rst = 1'b0; psel = 3'b0; PEnable = 1'b0; PWrite = 1'b0;
    PAddr = 16'h0; PWData = 32'h0;

    #50;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", {31'b0, rdy[k]}, 32'h0);
      check("rst_slverr", {31'b0, slverr[k]}, 32'h0);
      check("rst_prdata", prdata[k], 32'h0);
    end
    #50 Rst = 1'b1;

    // Zero-wait writes/reads, including back-to-back write then read.
    xfer(0, 16'h0050, 32'h0000_0050, 1'b1);
    xfer(0, 16'h0050, 32'h0, 1'b0);
    xfer(0, 16'h0051, 32'hCAFE_0051, 1'b1);
    xfer(0, 16'h0051, 32'h0, 1'b0);

    // Out-of-range write aliases to index 0 in the low bits; it must not land.
    xfer(0, 16'h0000, 32'hA5A5_A5A5, 1'b1);
    xfer(0, 16'h0100, 32'h0000_1234, 1'b1);
    xfer(0, 16'h0100, 32'h0, 1'b0);
    xfer(0, 16'h00FF, 32'h0F0F_00FF, 1'b1);

    // Two wait states, with PAddr/PWData toggled during the wait.
    xfer(1, 16'h0010, 32'hDEAD_BEEF, 1'b1);
    xfer(1, 16'h0010, 32'h0, 1'b0);
    check("w2_no_alias", mem_word(1, 8'hEF), mdl[1][8'hEF]);

    // Three wait states: normal write, then PSel dropped in the 2nd wait cycle.
    xfer(2, 16'h0021, 32'h3333_4444, 1'b1);
    @(negedge clk);
    psel[2] = 1'b1; PEnable = 1'b0; PAddr = 16'h0020; PWData = 32'h1111_2222; PWrite = 1'b1;
    @(negedge clk);
    PEnable = 1'b1;
    check("abort_wait1", {31'b0, rdy[2]}, 32'h0);
    @(negedge clk);
    check("abort_wait2", {31'b0, rdy[2]}, 32'h0);
    psel[2] = 1'b0; PEnable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_ready", {31'b0, rdy[2]}, 32'h0);
    end
    check("abort_no_write", mem_word(2, 8'h20), mdl[2][8'h20]);

    // PSel and PEnable together from IDLE: no setup phase, so nothing happens.
    @(negedge clk);
    psel[0] = 1'b1; PEnable = 1'b1; PWrite = 1'b1; PAddr = 16'h0060; PWData = 32'h0000_0066;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("nosetup_no_ready", {31'b0, rdy[0]}, 32'h0);
    end
    psel[0] = 1'b0; PEnable = 1'b0;
    @(negedge clk);
    check("nosetup_no_write", mem_word(0, 8'h60), mdl[0][8'h60]);

    // Reset in the middle of a waited write.
    xfer(2, 16'h0021, 32'h0, 1'b0);
    @(negedge clk);
    psel[2] = 1'b1; PEnable = 1'b0; PAddr = 16'h0021; PWData = 32'h5555_5555; PWrite = 1'b1;
    @(negedge clk);
    PEnable = 1'b1;
    check("pre_rst_prdata", prdata[2], 32'h3333_4444);
    #2 Rst = 1'b0;
    #1;
    check("mid_rst_prdata", prdata[2], 32'h0);
    check("mid_rst_ready", {31'b0, rdy[2]}, 32'h0);
    check("mid_rst_slverr", {31'b0, slverr[2]}, 32'h0);
    @(negedge clk);
    psel[2] = 1'b0; PEnable = 1'b0;
    @(negedge clk);
    Rst = 1'b1;
    check("rst_no_write", mem_word(2, 8'h21), mdl[2][8'h21]);

    // Transfers resume normally and memory contents survived the reset.
    xfer(2, 16'h0022, 32'h0000_0077, 1'b1);
    xfer(2, 16'h0022, 32'h0, 1'b0);
    xfer(0, 16'h0050, 32'h0, 1'b0);
    xfer(1, 16'h0010, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
